// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared-ALU, single-memory datapath and counts retired instructions.
module mips_multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [5:0]       i_opcode,
    input  logic             i_memReady,
    output logic             o_pcWrite,
    output logic             o_pcWriteCond,
    output logic             o_bne,
    output logic             o_iorD,
    output logic             o_memRead,
    output logic             o_memWrite,
    output logic             o_irWrite,
    output logic             o_memToReg,
    output logic             o_regDst,
    output logic             o_regWrite,
    output logic             o_aluSrcA,
    output logic [1:0]       o_aluSrcB,
    output logic [1:0]       o_aluOp,
    output logic [1:0]       o_pcSrc,
    output logic             o_extOp,
    output logic             o_illegal,
    output logic             o_instrDone,
    output logic [CNT_W-1:0] o_retired,
    output logic [3:0]       o_state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXEC = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] retired_r;

    // State register and retired-instruction counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= S_FETCH;
            retired_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (o_instrDone) begin
                retired_r <= retired_r + CNT_W'(1);
            end else begin
                retired_r <= retired_r;
            end
        end
    end

    // Next-state and Moore/strobe output decode; everything stays 0 under reset
    always_comb begin
        state_next_s  = S_FETCH;
        o_pcWrite     = 1'b0;
        o_pcWriteCond = 1'b0;
        o_bne         = 1'b0;
        o_iorD        = 1'b0;
        o_memRead     = 1'b0;
        o_memWrite    = 1'b0;
        o_irWrite     = 1'b0;
        o_memToReg    = 1'b0;
        o_regDst      = 1'b0;
        o_regWrite    = 1'b0;
        o_aluSrcA     = 1'b0;
        o_aluSrcB     = 2'b00;
        o_aluOp       = 2'b00;
        o_pcSrc       = 2'b00;
        o_extOp       = 1'b0;
        o_illegal     = 1'b0;
        o_instrDone   = 1'b0;
        o_state       = 4'd0;
        if (!i_rst) begin
            o_state = state_r;
            case (state_r)
                S_FETCH: begin
                    o_memRead    = 1'b1;
                    o_aluSrcB    = 2'b01;
                    o_irWrite    = i_memReady;
                    o_pcWrite    = i_memReady;
                    state_next_s = i_memReady ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    o_aluSrcB = 2'b11;
                    case (i_opcode)
                        OP_LW, OP_SW:     state_next_s = S_MEMADR;
                        OP_RTYPE:         state_next_s = S_RTEXEC;
                        OP_ADDI, OP_ADDIU, OP_SLTI,
                        OP_ANDI, OP_ORI, OP_XORI:
                                          state_next_s = S_IEXEC;
                        OP_BEQ, OP_BNE:   state_next_s = S_BRANCH;
                        OP_J:             state_next_s = S_JUMP;
                        default: begin
                            o_illegal    = 1'b1;
                            state_next_s = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    o_aluSrcA = 1'b1;
                    o_aluSrcB = 2'b10;
                    case (i_opcode)
                        OP_LW:   state_next_s = S_MEMRD;
                        OP_SW:   state_next_s = S_MEMWR;
                        default: state_next_s = S_FETCH;
                    endcase
                end
                S_MEMRD: begin
                    o_memRead    = 1'b1;
                    o_iorD       = 1'b1;
                    state_next_s = i_memReady ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    o_memToReg  = 1'b1;
                    o_regWrite  = 1'b1;
                    o_instrDone = 1'b1;
                end
                S_MEMWR: begin
                    o_memWrite   = 1'b1;
                    o_iorD       = 1'b1;
                    o_instrDone  = i_memReady;
                    state_next_s = i_memReady ? S_FETCH : S_MEMWR;
                end
                S_RTEXEC: begin
                    o_aluSrcA    = 1'b1;
                    o_aluOp      = 2'b10;
                    state_next_s = S_RTWB;
                end
                S_RTWB: begin
                    o_regDst    = 1'b1;
                    o_regWrite  = 1'b1;
                    o_instrDone = 1'b1;
                end
                S_IEXEC: begin
                    o_aluSrcA    = 1'b1;
                    o_aluSrcB    = 2'b10;
                    o_aluOp      = 2'b11;
                    o_extOp      = (i_opcode == OP_ANDI) || (i_opcode == OP_ORI) ||
                                   (i_opcode == OP_XORI);
                    state_next_s = S_IWB;
                end
                S_IWB: begin
                    o_regWrite  = 1'b1;
                    o_instrDone = 1'b1;
                end
                S_BRANCH: begin
                    o_aluSrcA     = 1'b1;
                    o_aluOp       = 2'b01;
                    o_pcSrc       = 2'b01;
                    o_instrDone   = 1'b1;
                    o_pcWriteCond = (i_opcode == OP_BEQ);
                    o_bne         = (i_opcode == OP_BNE);
                end
                S_JUMP: begin
                    o_pcSrc     = 2'b10;
                    o_pcWrite   = 1'b1;
                    o_instrDone = 1'b1;
                end
                default: state_next_s = S_FETCH;
            endcase
        end else begin
            state_next_s = S_FETCH;
        end
    end

    assign o_retired = i_rst ? {CNT_W{1'b0}} : retired_r;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: reset, opcode sweep, stalls,
// illegal opcode, reset mid-store and retired-counter wrap (CNT_W=4).
module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       i_rst;
    logic [5:0] i_opcode;
    logic       i_memReady;
    logic       o_pcWrite, o_pcWriteCond, o_bne, o_iorD, o_memRead, o_memWrite;
    logic       o_irWrite, o_memToReg, o_regDst, o_regWrite, o_aluSrcA;
    logic [1:0] o_aluSrcB, o_aluOp, o_pcSrc;
    logic       o_extOp, o_illegal, o_instrDone;
    logic [3:0] o_retired;
    logic [3:0] o_state;

    int n_vec = 0;
    int n_err = 0;

    mips_multicycle_ctrl #(.CNT_W(4)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_memReady(i_memReady),
        .o_pcWrite(o_pcWrite), .o_pcWriteCond(o_pcWriteCond), .o_bne(o_bne),
        .o_iorD(o_iorD), .o_memRead(o_memRead), .o_memWrite(o_memWrite),
        .o_irWrite(o_irWrite), .o_memToReg(o_memToReg), .o_regDst(o_regDst),
        .o_regWrite(o_regWrite), .o_aluSrcA(o_aluSrcA), .o_aluSrcB(o_aluSrcB),
        .o_aluOp(o_aluOp), .o_pcSrc(o_pcSrc), .o_extOp(o_extOp),
        .o_illegal(o_illegal), .o_instrDone(o_instrDone), .o_retired(o_retired),
        .o_state(o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {aluSrcA, aluSrcB, aluOp, pcSrc, iorD, memRead, memWrite, regDst, memToReg, regWrite}
    logic [12:0] ctrl;
    assign ctrl = {o_aluSrcA, o_aluSrcB, o_aluOp, o_pcSrc, o_iorD, o_memRead,
                   o_memWrite, o_regDst, o_memToReg, o_regWrite};

    logic [31:0] all_out;
    assign all_out = {ctrl, o_pcWrite, o_pcWriteCond, o_bne, o_irWrite, o_extOp,
                      o_illegal, o_instrDone, o_retired, o_state};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // per-instruction statistics filled by run_instr
    int          lat, ir_cnt, pcw_f, pcw_x, rw_cnt, m2r_cnt, mw_cnt;
    int          pwc_cnt, bne_cnt, ext_ie, ext_other, ill_cnt, done_cnt, both_cnt;
    logic [63:0] seq;
    logic [3:0]  post_state;
    logic [3:0]  post_ret;

    task automatic run_instr(input logic [5:0] op, input int fs, input int ms);
        logic [3:0]  st;
        logic [12:0] exp_c;
        int          fcnt, mcnt;
        bit          done;
        lat = 0; ir_cnt = 0; pcw_f = 0; pcw_x = 0; rw_cnt = 0; m2r_cnt = 0; mw_cnt = 0;
        pwc_cnt = 0; bne_cnt = 0; ext_ie = 0; ext_other = 0; ill_cnt = 0;
        done_cnt = 0; both_cnt = 0; seq = 64'd0;
        fcnt = 0; mcnt = 0; done = 1'b0;
        i_opcode = op;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            st = o_state;
            if (st == 4'd0) begin
                i_memReady = (fcnt >= fs);
                fcnt++;
            end else if (st == 4'd3 || st == 4'd5) begin
                i_memReady = (mcnt >= ms);
                mcnt++;
            end else begin
                i_memReady = 1'b1;
            end
            #1;
            lat++;
            seq = {seq[59:0], st};
            if (o_irWrite) ir_cnt++;
            if (o_pcWrite && st == 4'd0) pcw_f++;
            if (o_pcWrite && st != 4'd0) pcw_x++;
            if (o_regWrite) rw_cnt++;
            if (o_regWrite && o_memToReg) m2r_cnt++;
            if (o_memWrite) mw_cnt++;
            if (o_pcWriteCond) pwc_cnt++;
            if (o_bne) bne_cnt++;
            if (o_extOp && st == 4'd10) ext_ie++;
            if (o_extOp && st != 4'd10) ext_other++;
            if (o_illegal) ill_cnt++;
            if (o_instrDone) done_cnt++;
            if (o_instrDone && o_illegal) both_cnt++;
            case (st)
                4'd0:    exp_c = 13'b0_01_00_00_010000;
                4'd1:    exp_c = 13'b0_11_00_00_000000;
                4'd2:    exp_c = 13'b1_10_00_00_000000;
                4'd3:    exp_c = 13'b0_00_00_00_110000;
                4'd4:    exp_c = 13'b0_00_00_00_000011;
                4'd5:    exp_c = 13'b0_00_00_00_101000;
                4'd6:    exp_c = 13'b1_00_10_00_000000;
                4'd7:    exp_c = 13'b0_00_00_00_000101;
                4'd8:    exp_c = 13'b1_00_01_01_000000;
                4'd9:    exp_c = 13'b0_00_00_10_000000;
                4'd10:   exp_c = 13'b1_10_11_00_000000;
                4'd11:   exp_c = 13'b0_00_00_00_000001;
                default: exp_c = 13'h1fff;
            endcase
            check_val($sformatf("ctrl_op%0h_st%0d", op, st), ctrl, exp_c);
            if (o_instrDone || o_illegal) done = 1'b1;
        end
        if (!done) check_val("retire_timeout", 0, 1);
        @(posedge clk);
        #1;
        post_state = o_state;
        post_ret   = o_retired;
    endtask

    logic [5:0]  ops  [12];
    int          lats [12];
    logic [63:0] seqs [12];

    initial begin
        ops[0]  = 6'b000000; lats[0]  = 4; seqs[0]  = 64'h0167;
        ops[1]  = 6'b001000; lats[1]  = 4; seqs[1]  = 64'h01AB;
        ops[2]  = 6'b001001; lats[2]  = 4; seqs[2]  = 64'h01AB;
        ops[3]  = 6'b001010; lats[3]  = 4; seqs[3]  = 64'h01AB;
        ops[4]  = 6'b001100; lats[4]  = 4; seqs[4]  = 64'h01AB;
        ops[5]  = 6'b001101; lats[5]  = 4; seqs[5]  = 64'h01AB;
        ops[6]  = 6'b001110; lats[6]  = 4; seqs[6]  = 64'h01AB;
        ops[7]  = 6'b100011; lats[7]  = 5; seqs[7]  = 64'h01234;
        ops[8]  = 6'b101011; lats[8]  = 4; seqs[8]  = 64'h0125;
        ops[9]  = 6'b000100; lats[9]  = 3; seqs[9]  = 64'h018;
        ops[10] = 6'b000101; lats[10] = 3; seqs[10] = 64'h018;
        ops[11] = 6'b000010; lats[11] = 3; seqs[11] = 64'h019;

        // reset with memory not ready
        i_rst = 1'b1; i_memReady = 1'b0; i_opcode = 6'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check_val("reset_outputs_zero", all_out, 0);
        end
        @(negedge clk);
        i_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_val("idle_state", o_state, 4'd0);
            check_val("idle_memRead", o_memRead, 1'b1);
            check_val("idle_irWrite", o_irWrite, 1'b0);
            check_val("idle_retired", o_retired, 4'd0);
        end

        // opcode sweep, memory always ready
        for (int k = 0; k < 12; k++) begin
            run_instr(ops[k], 0, 0);
            check_val($sformatf("sweep_lat_%0h", ops[k]), lat, lats[k]);
            check_val($sformatf("sweep_seq_%0h", ops[k]), seq, seqs[k]);
            check_val($sformatf("sweep_ext_%0h", ops[k]), ext_ie,
                      (ops[k] >= 6'h0C && ops[k] <= 6'h0E) ? 1 : 0);
            check_val($sformatf("sweep_extx_%0h", ops[k]), ext_other, 0);
            check_val($sformatf("sweep_pwc_%0h", ops[k]), pwc_cnt, (ops[k] == 6'h04) ? 1 : 0);
            check_val($sformatf("sweep_bne_%0h", ops[k]), bne_cnt, (ops[k] == 6'h05) ? 1 : 0);
            check_val($sformatf("sweep_pcwj_%0h", ops[k]), pcw_x, (ops[k] == 6'h02) ? 1 : 0);
            check_val($sformatf("sweep_done_%0h", ops[k]), done_cnt, 1);
            check_val($sformatf("sweep_post_%0h", ops[k]), post_state, 4'd0);
            check_val($sformatf("sweep_ret_%0h", ops[k]), post_ret, k + 1);
        end
        check_val("sweep_retired_12", post_ret, 4'd12);

        // LW with 3 fetch stalls and 2 read stalls
        run_instr(6'b100011, 3, 2);
        check_val("lw_stall_lat", lat, 10);
        check_val("lw_stall_seq", seq, 64'h0000123334);
        check_val("lw_stall_ir", ir_cnt, 1);
        check_val("lw_stall_pcw", pcw_f + pcw_x, 1);
        check_val("lw_stall_rw", rw_cnt, 1);
        check_val("lw_stall_m2r", m2r_cnt, 1);
        check_val("lw_stall_ret", post_ret, 4'd13);

        // illegal opcode
        run_instr(6'b111111, 0, 0);
        check_val("ill_pulse", ill_cnt, 1);
        check_val("ill_lat", lat, 2);
        check_val("ill_post", post_state, 4'd0);
        check_val("ill_rw", rw_cnt, 0);
        check_val("ill_mw", mw_cnt, 0);
        check_val("ill_pcw", pcw_x, 0);
        check_val("ill_done", done_cnt, 0);
        check_val("ill_both", both_cnt, 0);
        check_val("ill_ret", post_ret, 4'd13);

        // reset while a store waits for memory
        begin
            bit found;
            found = 1'b0;
            i_opcode = 6'b101011; i_memReady = 1'b1;
            for (int c = 0; c < 20 && !found; c++) begin
                @(negedge clk);
                if (o_state == 4'd5) found = 1'b1;
            end
            check_val("sw_reach_memwr", found, 1'b1);
            i_memReady = 1'b0;
            #1;
            check_val("sw_wait_memWrite", o_memWrite, 1'b1);
            @(negedge clk);
            #1;
            check_val("sw_hold_memWrite", o_memWrite, 1'b1);
            i_rst = 1'b1;
            #1;
            check_val("sw_rst_memWrite", o_memWrite, 1'b0);
            check_val("sw_rst_outputs", all_out, 0);
            @(negedge clk);
            i_rst = 1'b0;
            #1;
            check_val("sw_rst_state", o_state, 4'd0);
            check_val("sw_rst_memRead", o_memRead, 1'b1);
            check_val("sw_rst_retired", o_retired, 4'd0);
        end

        // 17 jumps to wrap the 4-bit counter
        for (int k = 1; k <= 17; k++) begin
            run_instr(6'b000010, 0, 0);
            check_val($sformatf("wrap_lat_%0d", k), lat, 3);
            check_val($sformatf("wrap_ret_%0d", k), post_ret, k % 16);
        end
        check_val("wrap_final", post_ret, 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
